// File: rtl/spi_pkg.sv
// Shared types for the SPI slave command/memory path.
//   cmd_t        : two-bit command field carried in the top of every RX frame
//   ctrl_state_t : read-sequencing states of spi_ram_ctrl
//   CTRL_WIDTH   : width of the command field
package spi_pkg;

  localparam int CTRL_WIDTH = 2;

  typedef enum logic [CTRL_WIDTH-1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    TX
  } ctrl_state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM, synchronous write, registered read, no reset on the array.
//   clk   : rising-edge clock
//   en    : port enable (read or write this cycle)
//   we    : write when en=1, otherwise read
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read
module sp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder and memory behind the SPI slave. Decodes one command per
// rising edge of rx_valid, owns the RAM and the write/read address registers,
// and returns read data to the slave.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   rx_valid : frame-complete level from the slave (high until CS deasserts)
//   rx_data  : {cmd[1:0], payload[FRAME_WIDTH-1:0]}
//   tx_valid : read data available to the slave
//   tx_data  : read data
//   cmd_err  : one-cycle pulse on RD_DATA with no read address armed
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_WIDTH = 8,
  parameter int MEM_DEPTH   = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [FRAME_WIDTH+1:0] rx_data,
  output logic                   tx_valid,
  output logic [FRAME_WIDTH-1:0] tx_data,
  output logic                   cmd_err
);

  localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  cmd_t                   cmd_p0;
  logic [FRAME_WIDTH-1:0] payload_p0;
  logic                   rx_valid_q;
  logic                   accept_p0;
  logic [ADDR_W-1:0]      wr_addr;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   rd_armed;
  logic                   ram_en;
  logic                   ram_we;
  logic                   ram_re;
  logic [ADDR_W-1:0]      ram_addr;
  logic [FRAME_WIDTH-1:0] ram_rd_p1;
  ctrl_state_t            state;
  ctrl_state_t            state_nxt;
  logic                   tx_load;

  // ---- stage p0: edge detect and command decode ----
  assign cmd_p0     = cmd_t'(rx_data[FRAME_WIDTH+1:FRAME_WIDTH]);
  assign payload_p0 = rx_data[FRAME_WIDTH-1:0];
  assign accept_p0  = rx_valid & ~rx_valid_q;

  // rst gates the write strobe directly so a write coinciding with an
  // asynchronous reset never lands in the (unreset) array.
  assign ram_we   = accept_p0 & (cmd_p0 == WR_DATA) & ~rst;
  assign ram_re   = accept_p0 & (cmd_p0 == RD_DATA);
  assign ram_en   = ram_we | ram_re;
  assign ram_addr = ram_we ? wr_addr : rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      rd_armed   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      cmd_err    <= ram_re & ~rd_armed;
      if (accept_p0) begin
        case (cmd_p0)
          WR_ADDR: wr_addr <= payload_p0[ADDR_W-1:0];
          RD_ADDR: begin
            rd_addr  <= payload_p0[ADDR_W-1:0];
            rd_armed <= 1'b1;
          end
          RD_DATA: rd_armed <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // ---- stage p1: RAM registered output ----
  sp_ram #(
    .DATA_WIDTH (FRAME_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (payload_p0),
    .rdata (ram_rd_p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // RD_WAIT covers the RAM output register; an rx_valid drop there aborts
  // the read before tx_valid is ever raised.
  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    case (state)
      IDLE: if (ram_re) state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (!rx_valid) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = TX;
          tx_load   = 1'b1;
        end
      end
      TX: if (!rx_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p2: output registers ----
  // tx_data only loads on entry to TX, so it holds steady while tx_valid=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_valid <= (state_nxt == TX);
      if (tx_load) tx_data <= ram_rd_p1;
    end
  end

endmodule
